out_port_arb_ctrl: RTL



---
 rtl/out_port_arb_ctrl_if.sv | 29 ++
 rtl/out_port_arb_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/out_port_arb_ctrl_if.sv
// Shared transaction type and the arbiter's request/link bundle.
// master = arbiter side, slave = FIFO/link side.
package router_pkg;
   typedef struct packed {
      logic [3:0]  dest;
      logic [31:0] data;
   } t_tile_trans;
endpackage

interface out_port_arb_ctrl_if;
   import router_pkg::*;

   logic [3:0]        valid_req;
   t_tile_trans [0:3] req;
   logic [3:0]        req_ready;
   logic              credit_return;
   logic              out_valid;
   t_tile_trans       out_req;

   modport master (
      input  valid_req, req, credit_return,
      output req_ready, out_valid, out_req
   );

   modport slave (
      output valid_req, req, credit_return,
      input  req_ready, out_valid, out_req
   );
endinterface

// File: rtl/out_port_arb_ctrl.sv
// Credit-based round-robin arbiter for one router output port (4 requesters).
// Optional per-requester grant statistics under ROUTER_ARB_STATS_EN.
`ifdef ROUTER_ARB_STATS_EN
module out_port_arb_grant_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [15:0] cnt
);
   always_ff @(posedge clk) begin
      if (rst)                        cnt <= '0;
      else if (inc && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
   end
endmodule
`endif

module out_port_arb_ctrl
   import router_pkg::*;
#(
   parameter int NUM_CREDITS = 4,
   parameter int CNT_W       = $clog2(NUM_CREDITS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   out_port_arb_ctrl_if.master  link,
   output logic [CNT_W-1:0]     credit_cnt,
   output logic                 credit_err,
   output logic [0:3][15:0]     grant_cnt
);
   typedef enum logic {SEND, STALL} state_t;

   state_t           state_q, state_d;
   logic [1:0]       rr_ptr;
   logic [1:0]       winner;
   logic             found;
   logic             grant;
   logic [3:0]       pop;
   logic [CNT_W-1:0] cnt_d;
   logic             err_set;

   // Rotating priority search starting at rr_ptr.
   always_comb begin
      logic [1:0] idx;
      idx    = '0;
      found  = 1'b0;
      winner = '0;
      for (int k = 0; k < 4; k++) begin
         idx = rr_ptr + 2'(k);
         if (!found && link.valid_req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign grant          = (state_q == SEND) && (credit_cnt != '0) && found;
   assign pop            = grant ? (4'b0001 << winner) : 4'b0000;
   assign link.req_ready = pop;

   // Credit next-value; a simultaneous grant and return cancel out.
   always_comb begin
      cnt_d   = credit_cnt;
      err_set = 1'b0;
      case ({grant, link.credit_return})
         2'b10: cnt_d = credit_cnt - CNT_W'(1);
         2'b01: begin
            if (credit_cnt == CNT_W'(NUM_CREDITS)) err_set = 1'b1;
            else                                   cnt_d   = credit_cnt + CNT_W'(1);
         end
         default: ;
      endcase
   end

   // State follows the next credit value, so a return seen in STALL
   // reopens the port on the very next cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SEND:    if (cnt_d == '0) state_d = STALL;
         STALL:   if (cnt_d != '0) state_d = SEND;
         default: state_d = SEND;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= SEND;
         rr_ptr         <= '0;
         credit_cnt     <= CNT_W'(NUM_CREDITS);
         credit_err     <= 1'b0;
         link.out_valid <= 1'b0;
         link.out_req   <= '0;
      end else begin
         state_q        <= state_d;
         credit_cnt     <= cnt_d;
         link.out_valid <= grant;
         if (err_set) credit_err <= 1'b1;
         if (grant) begin
            link.out_req <= link.req[winner];
            rr_ptr       <= winner + 2'd1;
         end
      end
   end

`ifdef ROUTER_ARB_STATS_EN
   for (genvar i = 0; i < 4; i++) begin : g_stat
      out_port_arb_grant_cnt u_cnt (
         .clk (clk),
         .rst (rst),
         .inc (pop[i]),
         .cnt (grant_cnt[i])
      );
   end
`else
   assign grant_cnt = '0;
`endif

endmodule
